// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared frame-buffer geometry, pixel type and sequencer state encoding
package render_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int COLOR_W   = 12;
  localparam int ADDR_W    = 17;

  typedef logic [COLOR_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RENDER = 2'd2
  } seq_state_t;

  function automatic int clamp_count(input int count, input int depth);
    return (count > depth) ? depth : count;
  endfunction

endpackage

// File: rtl/fb_clear_counter.sv
// rtl/fb_clear_counter.sv - walks frame-buffer addresses 0..COUNT-1, one per cycle after start
module fb_clear_counter #(
  parameter int COUNT  = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((COUNT == 0) ? 0 : COUNT - 1);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    if (start && COUNT != 0) begin
      busy_d = 1'b1;
      addr_d = '0;
    end else if (busy_q) begin
      if (addr_q == LAST_ADDR) busy_d = 1'b0;
      else                     addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
    end
  end

  assign busy = busy_q;
  assign last = busy_q && (addr_q == LAST_ADDR);
  assign addr = addr_q;

endmodule

// File: rtl/render_frame_sequencer.sv
// rtl/render_frame_sequencer.sv - IDLE->CLEAR->RENDER frame sequencer owning the frame-buffer write port
// Optional RENDER timeout enabled by defining RENDER_WATCHDOG_EN.
module render_frame_sequencer
  import render_pkg::*;
#(
  parameter int PIXEL_RESET_COUNT = 76800,
  parameter int FB_DEPTH          = render_pkg::FB_DEPTH,
  parameter int ADDR_W            = render_pkg::ADDR_W,
  parameter int COLOR_W           = render_pkg::COLOR_W,
  parameter int FRAME_W           = 8,
  parameter int WDOG_CYCLES       = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               skip_clear,
  input  logic               increment_frame,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               raster_start,
  input  logic               raster_done,
  input  logic               raster_we,
  input  logic [ADDR_W-1:0]  raster_addr,
  input  logic [COLOR_W-1:0] raster_data,
  output logic               raster_ready,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic [1:0]         state,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               frame_done,
  output logic               timeout
);

  localparam int CLEAR_N = clamp_count(PIXEL_RESET_COUNT, FB_DEPTH);

  seq_state_t         state_q, state_d;
  logic               start_q, inc_q;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic               raster_start_q, raster_start_d;
  logic               frame_done_q, frame_done_d;
  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;
  logic               timeout_q, timeout_d;

  logic               start_ev, inc_ev, done_ok, wdog_expire;
  logic               clr_start, clr_busy, clr_last;
  logic [ADDR_W-1:0]  clr_addr;

  assign start_ev  = start && !start_q;
  assign inc_ev    = increment_frame && !inc_q;
  assign clr_start = (state_q == IDLE) && start_ev && !skip_clear;
  // The done pulse that races the launch pulse belongs to a previous job.
  assign done_ok   = raster_done && !raster_start_q;

  fb_clear_counter #(
    .COUNT  (CLEAR_N),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .busy  (clr_busy),
    .last  (clr_last),
    .addr  (clr_addr)
  );

`ifdef RENDER_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign wdog_d      = (state_q == RENDER) ? wdog_q + 1'b1 : '0;
  assign wdog_expire = (state_q == RENDER) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // fb_* are registered, so each state computes what the port shows next cycle.
  always_comb begin
    state_d        = state_q;
    color_d        = color_q;
    frame_idx_d    = frame_idx_q;
    raster_start_d = 1'b0;
    frame_done_d   = 1'b0;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_data_d      = fb_data_q;
    timeout_d      = timeout_q;
    case (state_q)
      IDLE: begin
        if (inc_ev) frame_idx_d = frame_idx_q + 1'b1;
        if (start_ev) begin
          color_d = clear_color;
          if (!skip_clear && CLEAR_N != 0) begin
            state_d   = CLEAR;
            fb_we_d   = 1'b1;
            fb_addr_d = '0;
            fb_data_d = clear_color;
          end else begin
            state_d        = RENDER;
            raster_start_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (!clr_busy || clr_last) begin
          state_d        = RENDER;
          raster_start_d = 1'b1;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = clr_addr + 1'b1;
          fb_data_d = color_q;
        end
      end
      RENDER: begin
        if (raster_we) begin
          fb_we_d   = 1'b1;
          fb_addr_d = raster_addr;
          fb_data_d = raster_data;
        end
        if (done_ok) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (wdog_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      inc_q          <= 1'b0;
      color_q        <= '0;
      frame_idx_q    <= '0;
      raster_start_q <= 1'b0;
      frame_done_q   <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_data_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start;
      inc_q          <= increment_frame;
      color_q        <= color_d;
      frame_idx_q    <= frame_idx_d;
      raster_start_q <= raster_start_d;
      frame_done_q   <= frame_done_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_q      <= fb_data_d;
      timeout_q      <= timeout_d;
    end
  end

  assign state        = state_q;
  assign raster_ready = (state_q == RENDER);
  assign raster_start = raster_start_q;
  assign frame_done   = frame_done_q;
  assign frame_idx    = frame_idx_q;
  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign timeout      = timeout_q;

endmodule
